// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-channel hex/decimal
// display, sequential double-dabble BCD conversion, overflow dashes,
// leading-zero blanking and an update-hold control.
module seg7_scan_ctrl #(
  parameter  int DIGITS  = 8,
  parameter  int NCH     = 8,
  parameter  int CLK_DIV = 100_000,
  localparam int DW      = 4*DIGITS,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW-1:0]     sel,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_dec,
  input  logic              upd_en,
  input  logic              blank_lz,
  output logic              busy,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW    = $clog2(DW+1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [DG_W-1:0]   dig;
  logic [DW-1:0]     src, bcd, res, disp;
  logic [DW-1:0]     bcd_adj, bcd_nx;
  logic              ovf, ovf_nx, disp_ovf;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     sel_data;
  logic              sel_dec;
  logic [DG_W-1:0]   msd;
  logic [3:0]        nib;
  logic              blank;

  assign tick = (div_cnt == DIV_W'(CLK_DIV-1));
  assign busy = (state_q != IDLE);

  // scan prescaler
  always_ff @(posedge clk) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // digit index, one slot per tick, wraps after the last digit
  always_ff @(posedge clk) begin
    if (!rst_n) dig <= '0;
    else if (tick) dig <= (dig == DG_W'(DIGITS-1)) ? '0 : dig + 1'b1;
  end

  // selected channel; an out-of-range select reads as zero/hex
  always_comb begin
    sel_data = '0;
    sel_dec  = 1'b0;
    if (int'(sel) < NCH) begin
      sel_data = ch_data[int'(sel)*DW +: DW];
      sel_dec  = ch_dec[sel];
    end
  end

  // one double-dabble step: add-3 on nibbles >=5, then shift {bcd,src} left
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_nx = {bcd_adj[DW-2:0], src[DW-1]};
    ovf_nx = ovf | bcd_adj[DW-1];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; ticks outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick && upd_en) state_d = sel_dec ? CONV : DONE;
      CONV:    if (cnt == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture, conversion datapath and atomic display update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src <= '0; bcd <= '0; res <= '0; ovf <= 1'b0; cnt <= '0;
      disp <= '0; disp_ovf <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (tick && upd_en) begin
          src <= sel_data;
          ovf <= 1'b0;
          if (sel_dec) begin
            bcd <= '0;
            cnt <= CW'(DW);
          end else begin
            res <= sel_data;
          end
        end
        CONV: begin
          bcd <= bcd_nx;
          src <= {src[DW-2:0], 1'b0};
          ovf <= ovf_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) res <= bcd_nx;
        end
        DONE: begin
          disp     <= res;
          disp_ovf <= ovf;
        end
        default: ;
      endcase
    end
  end

  // most significant nonzero nibble of the displayed value
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (disp[4*i +: 4] != 4'd0) msd = DG_W'(i);
  end

  assign nib   = disp[4*dig +: 4];
  assign blank = blank_lz && !disp_ovf && (dig > msd);

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = 8'hC0;  4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;  4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;  4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;  4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;  4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;  4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;  4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;  default: seg_lut = 8'h8E;
    endcase
  endfunction

  // registered digit drive; dash overrides blank overrides decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      AN  <= '1;
      SEG <= 8'hFF;
    end else begin
      AN <= ~(DIGITS'(1) << dig);
      if (disp_ovf)   SEG <= 8'hBF;
      else if (blank) SEG <= 8'hFF;
      else            SEG <= seg_lut(nib);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues the expected frame,
// a monitor checks busy length and a full scan frame after each update.
module tb_seg7_scan_ctrl;
  localparam int DIGITS  = 8;
  localparam int NCH     = 8;
  localparam int CLK_DIV = 50;
  localparam int DW      = 4*DIGITS;
  localparam int SW      = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW-1:0]     sel;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_dec;
  logic              upd_en, blank_lz, busy;
  logic [7:0]        SEG;
  logic [DIGITS-1:0] AN;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .NCH(NCH), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .ch_data(ch_data), .ch_dec(ch_dec),
    .upd_en(upd_en), .blank_lz(blank_lz), .busy(busy), .SEG(SEG), .AN(AN)
  );

  typedef struct {
    logic [DIGITS-1:0][7:0] seg;
    int busy_len;
    int frames;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, done_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [7:0] lut(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // reference: decimal digits by division, overflow when value needs >DIGITS digits
  function automatic exp_t model(input logic [31:0] v, input bit dec, input bit blz);
    exp_t   m;
    int     d[DIGITS];
    longint t;
    bit     ovf;
    int     msd;
    t   = longint'(v);
    ovf = dec && (t >= 64'd100000000);
    for (int i = 0; i < DIGITS; i++) begin
      if (dec) begin d[i] = int'(t % 10); t = t / 10; end
      else     d[i] = int'((v >> (4*i)) & 32'hF);
    end
    msd = 0;
    for (int i = 0; i < DIGITS; i++) if (d[i] != 0) msd = i;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf)                m.seg[i] = 8'hBF;
      else if (blz && i > msd) m.seg[i] = 8'hFF;
      else                    m.seg[i] = lut(d[i]);
    end
    m.busy_len = dec ? DW + 1 : 1;
    m.frames   = 1;
    return m;
  endfunction

  // monitor: each busy pulse is one DUT output event
  initial begin
    exp_t       e;
    int         len, ei;
    logic [7:0] pan, ean;
    forever begin
      @(negedge clk);
      if (mon_en && busy === 1'b1) begin
        len = 0;
        while (busy === 1'b1 && len < 500) begin len++; @(negedge clk); end
        if (q.size() == 0) fail_now("scoreboard_empty");
        else begin
          e = q.pop_front();
          chk("busy_len", len, e.busy_len);
          pan = AN; len = 0;
          while (AN === pan && len < 200) begin @(negedge clk); len++; end
          ei = 0;
          for (int i = 0; i < DIGITS; i++) if (AN === ~(8'd1 << i)) ei = i;
          for (int s = 0; s < DIGITS*e.frames; s++) begin
            ean = ~(8'd1 << ei);
            chk("an_digit", AN, ean);
            chk("seg_digit", SEG, e.seg[ei]);
            pan = AN; len = 0;
            while (AN === pan && len < 200) begin @(negedge clk); len++; end
            chk("slot_len", len, CLK_DIV);
            ei = (ei + 1) % DIGITS;
          end
        end
        done_cnt++;
      end
    end
  end

  task automatic do_update(input int c, input logic [31:0] v, input bit dec,
                           input bit blz, input int frames, input bit disturb);
    exp_t e;
    int   n, start;
    ch_data[c*DW +: DW] = v;
    ch_dec[c] = dec;
    sel       = SW'(c);
    blank_lz  = blz;
    e = model(v, dec, blz);
    e.frames = frames;
    q.push_back(e);
    start  = done_cnt;
    upd_en = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    upd_en = 1'b0;
    if (n >= 200) fail_now("capture_timeout");
    if (disturb) begin
      repeat (4) @(negedge clk);
      sel = SW'((c + 1) % NCH);
      ch_data[c*DW +: DW] = $urandom();
      ch_dec = ~ch_dec;
    end
    n = 0;
    while (done_cnt == start && n < frames*DIGITS*CLK_DIV + 800) begin @(negedge clk); n++; end
    if (done_cnt == start) fail_now("monitor_timeout");
  endtask

  initial begin
    logic [31:0] v;
    int          n;
    rst_n = 1'b0; sel = '0; ch_dec = '0; upd_en = 1'b0; blank_lz = 1'b0;
    for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = $urandom();
    repeat (3) @(negedge clk);
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("an_first", AN, 8'hFE);
    repeat (49) @(negedge clk);
    chk("an_before_tick", AN, 8'hFE);
    @(negedge clk);
    chk("an_after_tick", AN, 8'hFD);

    mon_en = 1'b1;
    do_update(0, 32'h1234ABCD, 1'b0, 1'b0, 1, 1'b0);
    do_update(1, 32'd12345678, 1'b1, 1'b0, 1, 1'b0);
    do_update(1, 32'd100000000, 1'b1, 1'b1, 1, 1'b0);
    do_update(1, 32'd0, 1'b1, 1'b1, 1, 1'b0);
    do_update(2, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b0);
    do_update(3, 32'd99999999, 1'b1, 1'b1, 1, 1'b0);
    do_update(5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1'b0);
    do_update(6, 32'h0000_0F00, 1'b0, 1'b1, 1, 1'b0);
    do_update(4, 32'd42, 1'b1, 1'b1, 2, 1'b1);

    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom();
        1:       v = $urandom_range(0, 99999999);
        2:       v = $urandom_range(0, 999);
        default: v = 32'd100000000 + $urandom_range(0, 200000000);
      endcase
      do_update($urandom_range(0, NCH-1), v, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1, 1'b0);
    end

    // reset in the middle of a conversion
    mon_en = 1'b0;
    blank_lz = 1'b0;
    ch_data[1*DW +: DW] = 32'd12345678;
    ch_dec[1] = 1'b1;
    sel = SW'(1);
    upd_en = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    upd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_mid_conv", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_an", AN, 8'hFF);
    chk("abort_seg", SEG, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_an", AN, 8'hFE);
    chk("post_abort_seg", SEG, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
